// File: rtl/mem_ctrl_resp_if.sv
// rtl/mem_ctrl_resp_if.sv - request, response and RAM bus bundle for mem_ctrl_resp
interface mem_ctrl_resp_if #(
  parameter int ADDR_W = 32
);
  logic [1:0]        memctl_op;
  logic [1:0]        memctl_len;
  logic [ADDR_W-1:0] memctl_addr;
  logic [31:0]       memctl_data;
  logic              memctl_fin;
  logic [31:0]       memctl_out;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_fin;
  logic [31:0]       if_out;
  logic [ADDR_W-1:0] mem_a;
  logic [7:0]        mem_dout;
  logic              mem_wr;
  logic [7:0]        mem_din;

  modport slave (
    input  memctl_op, memctl_len, memctl_addr, memctl_data, if_req, if_addr, mem_din,
    output memctl_fin, memctl_out, if_fin, if_out, mem_a, mem_dout, mem_wr
  );

  modport master (
    output memctl_op, memctl_len, memctl_addr, memctl_data, if_req, if_addr, mem_din,
    input  memctl_fin, memctl_out, if_fin, if_out, mem_a, mem_dout, mem_wr
  );
endinterface

// File: rtl/mem_ctrl_resp.sv
// rtl/mem_ctrl_resp.sv - byte-serial RAM controller serving the MEM data port and the IF fetch port
module mem_ctrl_resp #(
  parameter int ADDR_W = 32
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  input  logic           rdy_in,
  mem_ctrl_resp_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_SAVE = 2'b10;

  state_t            r_state;
  logic              r_port_if;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rbuf;
  logic [2:0]        r_len_n;
  logic [2:0]        r_issue_k;
  logic [2:0]        r_cap_k;
  logic              r_issued;
  logic              r_memctl_fin;
  logic              r_if_fin;
  logic [31:0]       r_memctl_out;
  logic [31:0]       r_if_out;
  logic [ADDR_W-1:0] r_mem_a;
  logic [7:0]        r_mem_dout;
  logic              r_mem_wr;

  logic              w_data_req;
  logic              w_data_save;
  logic [2:0]        w_req_n;
  logic [ADDR_W-1:0] w_req_addr;
  logic [ADDR_W-1:0] w_issue_addr;
  logic [7:0]        w_wr_byte;
  logic [31:0]       w_cap_word;

  assign w_data_req  = (bus.memctl_op == OP_LOAD) || (bus.memctl_op == OP_SAVE);
  assign w_data_save = (bus.memctl_op == OP_SAVE);
  assign w_req_addr  = w_data_req ? bus.memctl_addr : bus.if_addr;

  always_comb begin
    w_req_n = 3'd4;
    case (bus.memctl_len)
      2'b00:   w_req_n = 3'd1;
      2'b01:   w_req_n = 3'd2;
      default: w_req_n = 3'd4;
    endcase
  end

  assign w_issue_addr = r_addr + ADDR_W'(r_issue_k);
  assign w_wr_byte    = 8'(r_wdata >> {r_issue_k[1:0], 3'b000});
  assign w_cap_word   = {24'd0, bus.mem_din} << {r_cap_k[1:0], 3'b000};

  // r_issued marks "an address went out on the previous edge"; its capture ignores rdy_in
  // so a pause right after an issue neither drops nor repeats that byte.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state      <= IDLE;
      r_port_if    <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rbuf       <= '0;
      r_len_n      <= '0;
      r_issue_k    <= '0;
      r_cap_k      <= '0;
      r_issued     <= 1'b0;
      r_memctl_fin <= 1'b0;
      r_if_fin     <= 1'b0;
      r_memctl_out <= '0;
      r_if_out     <= '0;
      r_mem_a      <= '0;
      r_mem_dout   <= '0;
      r_mem_wr     <= 1'b0;
    end else begin
      r_memctl_fin <= 1'b0;
      r_if_fin     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (rdy_in && (w_data_req || bus.if_req)) begin
            r_port_if <= !w_data_req;
            r_addr    <= w_req_addr;
            r_wdata   <= bus.memctl_data;
            r_len_n   <= w_data_req ? w_req_n : 3'd4;
            r_issue_k <= 3'd1;
            r_cap_k   <= 3'd0;
            r_rbuf    <= '0;
            r_mem_a   <= w_req_addr;
            if (w_data_save) begin
              r_mem_dout <= bus.memctl_data[7:0];
              r_mem_wr   <= 1'b1;
              r_state    <= WRITE;
            end else begin
              r_issued <= 1'b1;
              r_state  <= READ;
            end
          end
        end
        READ: begin
          if (r_issued) begin
            r_rbuf  <= r_rbuf | w_cap_word;
            r_cap_k <= r_cap_k + 3'd1;
          end
          r_issued <= 1'b0;
          if (rdy_in) begin
            if (r_issue_k != r_len_n) begin
              r_mem_a   <= w_issue_addr;
              r_issued  <= 1'b1;
              r_issue_k <= r_issue_k + 3'd1;
            end else if (!r_issued && (r_cap_k == r_len_n)) begin
              r_state <= DONE;
              if (r_port_if) begin
                r_if_fin <= 1'b1;
                r_if_out <= r_rbuf;
              end else begin
                r_memctl_fin <= 1'b1;
                r_memctl_out <= r_rbuf;
              end
            end
          end
        end
        WRITE: begin
          if (rdy_in) begin
            if (r_issue_k != r_len_n) begin
              r_mem_a    <= w_issue_addr;
              r_mem_dout <= w_wr_byte;
              r_issue_k  <= r_issue_k + 3'd1;
            end else begin
              r_mem_wr     <= 1'b0;
              r_state      <= DONE;
              r_memctl_fin <= 1'b1;
              r_memctl_out <= '0;
            end
          end
        end
        DONE: begin
          if (rdy_in) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.memctl_fin = r_memctl_fin;
  assign bus.memctl_out = r_memctl_out;
  assign bus.if_fin     = r_if_fin;
  assign bus.if_out     = r_if_out;
  assign bus.mem_a      = r_mem_a;
  assign bus.mem_dout   = r_mem_dout;
  assign bus.mem_wr     = r_mem_wr & rdy_in;
endmodule
